bus_reader_fifo: RTL

Receive-side end of the shared tri-state data bus. Samples words that bus drivers (tri-state latch stages) place on the bus under a valid/ready handshake, buffers them in a small FIFO, and presents them in order to the consuming core logic with a show-ahead read port. It sits between the bus fabric and the CPU-side consumer, absorbing bursts while the consumer is stalled.

---
 rtl/bus_reader_fifo.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bus_reader_fifo.sv
// -----------------------------------------------------------------------------
// bus_reader_fifo
//
// Receive-side end of the shared tri-state data bus. Words placed on the bus
// under a valid/ready handshake are buffered in a small FIFO and presented in
// order to the consumer through a show-ahead read port.
//
// Parameters:
//   WIDTH  bus / data word width in bits
//   DEPTH  number of FIFO entries (power of two, >= 2)
//
// Ports:
//   clock      in   rising-edge clock for all state
//   reset      in   synchronous active-high reset
//   bus_data   in   word currently driven on the shared bus
//   bus_valid  in   driver asserts when bus_data holds a valid word
//   bus_ready  out  reader can accept a word this cycle (= !full)
//   rd_en      in   consumer pops the head entry
//   rd_data    out  head entry (show-ahead), 0 when empty
//   empty      out  FIFO holds 0 entries
//   full       out  FIFO holds DEPTH entries
//   count      out  current occupancy
//   overflow   out  sticky overflow flag
//
// Optional feature:
//   BUS_READER_OVERFLOW_EN  when defined, overflow is set whenever a driver
//                           presents a word while the FIFO is full, and stays
//                           set until reset. When undefined, overflow is tied
//                           to 0.
// -----------------------------------------------------------------------------
module bus_reader_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         bus_data,
  input  logic                     bus_valid,
  output logic                     bus_ready,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push;
  logic             pop;

  // Flags derive only from registered occupancy, so bus_ready has no
  // combinational path from rd_en: a pop while full frees space next cycle.
  assign empty     = (count_q == CW'(0));
  assign full      = (count_q == CW'(DEPTH));
  assign bus_ready = !full;
  assign count     = count_q;

  // Handshake qualification; a pop while empty is simply ignored.
  assign push = bus_valid && !full;
  assign pop  = rd_en && !empty;

  // Show-ahead head entry, forced to zero while empty since memory is not reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset wins over push and pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; the word in flight during a reset cycle is dropped.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= bus_data;
    end
  end

`ifdef BUS_READER_OVERFLOW_EN
  logic overflow_q;

  // Sticky record of a driver presenting a word while no space was available.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (bus_valid && full) begin
      overflow_q <= 1'b1;
    end else begin
      overflow_q <= overflow_q;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
